// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port memory: port 0 (CPU) has fixed
// priority, port 1 is guaranteed a slot after MAX_WAIT consecutive losses.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [7:0]  m1_rdata,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        mem_wrt_en,
    output logic        mem_chip_select
);

    localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;
    logic [1:0] gnt;
    logic [1:0] we_vec;
    logic       force_m1;

    assign we_vec = {m1_we, m0_we};
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_comb begin
        gnt      = 2'b00;
        force_m1 = m1_req && (wait_cnt_reg == MAX_WAIT_L);
        if (!rst) begin
            if (force_m1) begin
                gnt[1] = 1'b1;
            end else if (m0_req) begin
                gnt[0] = 1'b1;
            end else if (m1_req) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // Idle cycles park the memory bus at all-zero.
    always_comb begin
        mem_address     = 16'h0000;
        mem_data_in     = 8'h00;
        mem_wrt_en      = 1'b0;
        mem_chip_select = 1'b0;
        if (gnt[0]) begin
            mem_address     = m0_addr;
            mem_data_in     = m0_wdata;
            mem_wrt_en      = m0_we;
            mem_chip_select = 1'b1;
        end else if (gnt[1]) begin
            mem_address     = m1_addr;
            mem_data_in     = m1_wdata;
            mem_wrt_en      = m1_we;
            mem_chip_select = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (gnt[1] || !m1_req) begin
            wait_cnt_next = 8'h00;
        end else if (gnt[0] && (wait_cnt_reg < MAX_WAIT_L)) begin
            wait_cnt_next = wait_cnt_reg + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= 8'h00;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Per-port read return: capture on a granted read, hold until the next one.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_port
        logic       rvalid_reg;
        logic [7:0] rdata_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= 8'h00;
            end else begin
                rvalid_reg <= gnt[gi] && !we_vec[gi];
                if (gnt[gi] && !we_vec[gi]) begin
                    rdata_reg <= mem_data_out;
                end
            end
        end
    end

    assign m0_rvalid = gen_port[0].rvalid_reg;
    assign m0_rdata  = gen_port[0].rdata_reg;
    assign m1_rvalid = gen_port[1].rvalid_reg;
    assign m1_rdata  = gen_port[1].rdata_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port `memory` block (16-bit address, 8-bit data, combinational read, write on posedge `clk`) between the 6502 core (port 0) and a secondary bus master such as the program loader or DMA (port 1). Port 0 has fixed priority. A starvation counter guarantees port 1 a slot after `MAX_WAIT` consecutive lost cycles. The block sits between the masters and `memory`, owns `mem_address`, `mem_data_in`, `mem_wrt_en` and `mem_chip_select`, and returns registered read data to each master.

## Interface
- `MAX_WAIT`, default 4: number of consecutive cycles port 1 may request and lose before it is forced to win. Legal range 1..255.
- `clk` in 1: system clock; all state updates on posedge.
- `rst` in 1: reset; synchronous, active-high.
- `m0_req` in 1: port 0 (CPU) access request; held with its command until granted.
- `m0_we` in 1: port 0 write (1) / read (0).
- `m0_addr` in 16: port 0 address.
- `m0_wdata` in 8: port 0 write data.
- `m0_gnt` out 1: combinational grant; the transfer occurs in the cycle where `m0_req && m0_gnt`.
- `m0_rvalid` out 1: registered pulse one cycle after a granted read.
- `m0_rdata` out 8: registered read data; held until the next port 0 read completes.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as port 0, for port 1.
- `mem_address` out 16: address to `memory`.
- `mem_data_in` out 8: write data to `memory`.
- `mem_data_out` in 8: combinational read data from `memory`.
- `mem_wrt_en` out 1: write enable to `memory`.
- `mem_chip_select` out 1: high in any granted cycle.

## Operation
- Grant decision is combinational from `m0_req`, `m1_req`, `rst` and the starvation counter `wait_cnt` (8 bits):
  - If `rst` is high: no grant.
  - Else if `m1_req` and `wait_cnt == MAX_WAIT`: grant port 1 (forced).
  - Else if `m0_req`: grant port 0.
  - Else if `m1_req`: grant port 1.
  - Else: idle.
- At most one `gnt` is high per cycle. A `gnt` is never high unless its `req` is high.
- Memory mux, by grant:
  - Port 0 granted: drive `mem_*` from the `m0_*` command.
  - Port 1 granted: drive `mem_*` from the `m1_*` command.
  - Idle: `mem_address = 0`, `mem_data_in = 0`, `mem_wrt_en = 0`, `mem_chip_select = 0`.
- `mem_wrt_en = granted && granted_port_we`. The write takes effect at the posedge ending the grant cycle.
- Read: on the posedge ending the grant cycle, capture `mem_data_out` into the granted port's `rdata` and set that port's `rvalid` for exactly one cycle. A granted write produces no `rvalid` and does not change `rdata`.
- `wait_cnt` update on posedge:
  - `rst`: cleared to 0.
  - Port 1 granted: cleared to 0.
  - `m1_req` high and port 0 granted: incremented, saturating at `MAX_WAIT`.
  - `m1_req` low: cleared to 0.
- Masters may issue back-to-back requests. A port holding `req` high continuously is granted every cycle it wins.
- Command inputs of a port are don't-care while its `req` is low.

## Timing
- Reset values: `m0_rvalid = m1_rvalid = 0`, `m0_rdata = m1_rdata = 0`, `wait_cnt = 0`. `gnt` and all `mem_*` outputs are 0 while `rst` is high.
- Read latency: grant in cycle N, then `rvalid` and `rdata` valid in cycle N+1.
- Write latency: grant in cycle N, then memory content updated and visible to a read granted in cycle N+1.
- Worst-case port 1 wait under continuous port 0 traffic: `MAX_WAIT` lost cycles; granted on cycle `MAX_WAIT+1`.
- Port 0 yields exactly one cycle per forced port 1 grant.
- Reset mid-operation:
  - A read granted in the cycle before `rst` rises still completes: `rvalid` pulses in the `rst` cycle only if the grant preceded `rst`.
  - A pending `rvalid` is cleared on the next posedge with `rst` high.
  - No grant and no write occur in any cycle where `rst` is high.
- Simultaneous requests with `wait_cnt < MAX_WAIT`: port 0 wins.

## Test plan
- Reset: hold `rst` 3 cycles with both `req` high. Expect `gnt` = 0, `mem_wrt_en` = 0, `rvalid` = 0 and `rdata` = 0 throughout. First grant goes to port 0 in the cycle `rst` drops.
- Port 0 write/read: write 0xA5 to 0x0010 in cycle N, then read 0x0010 in cycle N+1. Expect `m0_rvalid` in N+2 with `m0_rdata = 0xA5`, and `m1_rdata` unchanged.
- Contention: both request every cycle with `MAX_WAIT` = 4. Expect grant pattern 0,0,0,0,1 repeating. `wait_cnt` reaches 4 and resets on each port 1 grant.
- Port 1 alone: reads of 0x0000..0x0003 back-to-back. Expect `m1_gnt` every cycle and `m1_rvalid` on 4 consecutive cycles, each with matching data.
- Port 1 drops `req` after 2 lost cycles, then re-requests. Expect `wait_cnt` restart from 0, so the forced grant comes 4 lost cycles after the re-request.
- Assert `rst` in the cycle after a port 1 read grant. Expect `m1_rvalid` high that cycle and 0 thereafter, and no `mem_wrt_en` during `rst`.
